// File: rtl/mem_tagged_responder_if.sv
// rtl/mem_tagged_responder_if.sv - processor/memory request-response bus bundle
interface mem_tagged_responder_if;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_address;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_address, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_address, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_tagged_responder.sv
// rtl/mem_tagged_responder.sv - tagged fixed-latency memory responder with in-order completions
// Optional macro MEM_RESP_STALL_INJECT_EN refuses requests one cycle in four.
module mem_tagged_responder #(
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_tagged_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  logic [63:0] mem        [MEM_WORDS];
  logic [3:0]  ent_tag_q  [DEPTH];
  logic        ent_load_q [DEPTH];
  logic [63:0] ent_data_q [DEPTH];
  logic [3:0]  ent_age_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0]       count_q, count_d, count_after;
  logic [3:0]       tag_ctr_q, tag_ctr_d;
  logic [3:0]       out_tag_q, out_tag_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0] idx;
  logic             is_req, completing, accept, stall, cand_due;
  logic             unused_addr_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef MEM_RESP_STALL_INJECT_EN
  logic [1:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= 2'd0;
    else       stall_cnt_q <= stall_cnt_q + 2'd1;
  end

  assign stall = (stall_cnt_q == 2'd3);
`else
  assign stall = 1'b0;
`endif

  assign idx              = bus.proc2mem_address[IDX_W+1:2];
  assign unused_addr_bits = ^{bus.proc2mem_address[63:IDX_W+2], bus.proc2mem_address[1:0]};

  always_comb begin
    is_req      = (bus.proc2mem_command == BUS_LOAD) || (bus.proc2mem_command == BUS_STORE);
    // The registered tag is nonzero exactly while the FIFO head is completing.
    completing  = (out_tag_q != 4'd0);
    count_after = count_q - {3'b000, completing};
    accept      = !reset && is_req && !stall && (count_after < 4'(DEPTH));

    head_d    = completing ? ptr_inc(head_q) : head_q;
    tail_d    = accept ? ptr_inc(tail_q) : tail_q;
    count_d   = count_after + {3'b000, accept};
    tag_ctr_d = tag_ctr_q;
    if (accept) tag_ctr_d = (tag_ctr_q == 4'd15) ? 4'd1 : tag_ctr_q + 4'd1;

    // Oldest surviving entry is due next cycle when it has aged LATENCY-1.
    cand_due   = (count_after != 4'd0) && (ent_age_q[head_d] == 4'(LATENCY - 1));
    out_tag_d  = cand_due ? ent_tag_q[head_d] : 4'd0;
    out_data_d = (cand_due && ent_load_q[head_d]) ? ent_data_q[head_d] : 64'd0;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) ent_age_q[i] <= ent_age_q[i] + 4'd1;
    if (accept) begin
      ent_tag_q[tail_q]  <= tag_ctr_q;
      ent_load_q[tail_q] <= (bus.proc2mem_command == BUS_LOAD);
      ent_data_q[tail_q] <= mem[idx];
      ent_age_q[tail_q]  <= 4'd1;
      if (bus.proc2mem_command == BUS_STORE) mem[idx] <= bus.proc2mem_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 4'd0;
      tag_ctr_q  <= 4'd1;
      out_tag_q  <= 4'd0;
      out_data_q <= 64'd0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tag_ctr_q  <= tag_ctr_d;
      out_tag_q  <= out_tag_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.mem2proc_response = accept ? tag_ctr_q : 4'd0;
  assign bus.mem2proc_tag      = out_tag_q;
  assign bus.mem2proc_data     = out_data_q;
endmodule

// File: tb/tb_mem_tagged_responder.sv
// tb/tb_mem_tagged_responder.sv - self-checking bench: default instance plus a DEPTH=2 instance
module tb_mem_tagged_responder;
  localparam int L     = 4;
  localparam int WORDS = 1024;
  localparam int D0    = 4;
  localparam int D1    = 2;
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_tagged_responder_if bus0 ();
  mem_tagged_responder_if bus1 ();

  mem_tagged_responder #(.LATENCY(L), .DEPTH(D0), .MEM_WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  mem_tagged_responder #(.LATENCY(L), .DEPTH(D1), .MEM_WORDS(WORDS)) dut2 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  typedef struct {
    logic [3:0]  tag;
    logic        is_load;
    logic [63:0] data;
    int          due;
  } pend_t;

  pend_t       q0[$];
  pend_t       q1[$];
  logic [3:0]  tagc [2];
  logic [63:0] mmem0 [WORDS];
  logic [63:0] mmem1 [WORDS];
  logic [71:0] obs_v [2];
  logic [71:0] exp_v [2];
  int          cyc;
  int          errors;
  int          checks;

  // Reference: each accepted request is due exactly L cycles after acceptance, retired in order.
  function automatic void model_step(int k, logic [1:0] cmd, logic [63:0] addr, logic [63:0] data, logic rst);
    pend_t h;
    int n, comp, depth, idx;
    logic acc;
    logic [3:0] e_tag;
    logic [63:0] e_data;
    depth  = (k == 0) ? D0 : D1;
    n      = (k == 0) ? q0.size() : q1.size();
    comp   = 0;
    e_tag  = 4'd0;
    e_data = 64'd0;
    if (n > 0) begin
      h = (k == 0) ? q0[0] : q1[0];
      if (h.due == cyc) begin
        comp   = 1;
        e_tag  = h.tag;
        e_data = h.is_load ? h.data : 64'd0;
      end
    end
    acc = !rst && (cmd == LOAD || cmd == STORE) && ((n - comp) < depth);
    exp_v[k] = {(acc ? tagc[k] : 4'd0), e_tag, e_data};
    if (comp == 1) begin
      if (k == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    idx = int'((addr >> 2) % 64'(WORDS));
    if (acc) begin
      h.tag     = tagc[k];
      h.is_load = (cmd == LOAD);
      h.data    = (k == 0) ? mmem0[idx] : mmem1[idx];
      h.due     = cyc + L;
      if (k == 0) q0.push_back(h);
      else        q1.push_back(h);
      if (cmd == STORE) begin
        if (k == 0) mmem0[idx] = data;
        else        mmem1[idx] = data;
      end
      tagc[k] = (tagc[k] == 4'd15) ? 4'd1 : tagc[k] + 4'd1;
    end
    if (rst) begin
      if (k == 0) q0.delete();
      else        q1.delete();
      tagc[k] = 4'd1;
    end
  endfunction

  task automatic run_cycle(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data, input logic rst);
    reset = rst;
    bus0.proc2mem_command = cmd;
    bus0.proc2mem_address = addr;
    bus0.proc2mem_data    = data;
    bus1.proc2mem_command = cmd;
    bus1.proc2mem_address = addr;
    bus1.proc2mem_data    = data;
    @(negedge clock);
    obs_v[0] = {bus0.mem2proc_response, bus0.mem2proc_tag, bus0.mem2proc_data};
    obs_v[1] = {bus1.mem2proc_response, bus1.mem2proc_tag, bus1.mem2proc_data};
    model_step(0, cmd, addr, data, rst);
    model_step(1, cmd, addr, data, rst);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] rand_addr(int w);
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    a[11:2] = 10'(w);
    return a;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(LOAD, 64'h40, 64'h0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== 72'd0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d cycle %0d: got %h, expected 0", k, cyc, obs_v[k]);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic [3:0] er, et;
    logic [63:0] ed;
    for (int c = 0; c <= 7; c++) begin
      if (c == 0)      run_cycle(NONE, 64'h0, 64'h0, 1'b1);
      else if (c == 1) run_cycle(STORE, 64'h10, 64'hDEADBEEF_00000001, 1'b0);
      else if (c == 2) run_cycle(LOAD, 64'h10, 64'h0, 1'b0);
      else             run_cycle(NONE, 64'h0, 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL store_load_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
      if (c >= 1) begin
        er = (c == 1) ? 4'd1 : (c == 2) ? 4'd2 : 4'd0;
        et = (c == 5) ? 4'd1 : (c == 6) ? 4'd2 : 4'd0;
        ed = (c == 6) ? 64'hDEADBEEF_00000001 : 64'd0;
        checks++;
        if (obs_v[0] !== {er, et, ed}) begin
          errors++;
          $display("FAIL store_load_directed cycle %0d: got %h, expected %h", c, obs_v[0], {er, et, ed});
        end
      end
    end
  endtask

  task automatic test_prime();
    for (int w = 0; w < 16; w++) begin
      run_cycle(STORE, rand_addr(w), {$urandom(), $urandom()}, 1'b0);
      run_cycle(NONE, 64'h0, 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL prime_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc1;
    run_cycle(NONE, 64'h0, 64'h0, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      run_cycle(LOAD, rand_addr(c % 16), 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL back_to_back_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
      checks++;
      if (obs_v[0][71:68] !== 4'(c)) begin
        errors++;
        $display("FAIL back_to_back_resp cycle %0d: got %0d, expected %0d", c, obs_v[0][71:68], c);
      end
      checks++;
      if (obs_v[0][67:64] !== ((c >= 5) ? 4'(c - 4) : 4'd0)) begin
        errors++;
        $display("FAIL back_to_back_tag cycle %0d: got %0d, expected %0d", c, obs_v[0][67:64], (c >= 5) ? c - 4 : 0);
      end
      acc1 = ((c - 1) % 4) < 2;
      checks++;
      if ((obs_v[1][71:68] != 4'd0) !== acc1) begin
        errors++;
        $display("FAIL depth2_accept cycle %0d: got resp %0d, expected accepted=%0d", c, obs_v[1][71:68], acc1);
      end
    end
  endtask

  task automatic test_tag_wrap();
    run_cycle(NONE, 64'h0, 64'h0, 1'b1);
    for (int c = 1; c <= 17 + L + 1; c++) begin
      if (c <= 17) run_cycle(LOAD, rand_addr(c % 16), 64'h0, 1'b0);
      else         run_cycle(NONE, 64'h0, 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL tag_wrap_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
      if (c <= 17) begin
        checks++;
        if (obs_v[0][71:68] !== 4'(((c - 1) % 15) + 1)) begin
          errors++;
          $display("FAIL tag_wrap_resp request %0d: got %0d, expected %0d", c, obs_v[0][71:68], ((c - 1) % 15) + 1);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    run_cycle(NONE, 64'h0, 64'h0, 1'b1);
    for (int c = 1; c <= 19; c++) begin
      if (c == 1)                run_cycle(STORE, 64'h14, v, 1'b0);
      else if (c >= 2 && c <= 4) run_cycle(LOAD, 64'h14, 64'h0, 1'b0);
      else if (c == 6)           run_cycle(NONE, 64'h0, 64'h0, 1'b1);
      else if (c == 15)          run_cycle(LOAD, 64'h14, 64'h0, 1'b0);
      else                       run_cycle(NONE, 64'h0, 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL reset_midflight_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
        if (c >= 7 && c <= 14) begin
          checks++;
          if (obs_v[k][67:0] !== 68'd0) begin
            errors++;
            $display("FAIL reset_no_completion dut%0d cycle %0d: got %h, expected 0", k, c, obs_v[k][67:0]);
          end
        end
        if (c == 15) begin
          checks++;
          if (obs_v[k][71:68] !== 4'd1) begin
            errors++;
            $display("FAIL reset_tag_restart dut%0d: got %0d, expected 1", k, obs_v[k][71:68]);
          end
        end
        if (c == 19) begin
          checks++;
          if (obs_v[k][67:0] !== {4'd1, v}) begin
            errors++;
            $display("FAIL reset_mem_kept dut%0d: got %h, expected %h", k, obs_v[k][67:0], {4'd1, v});
          end
        end
      end
    end
  endtask

  task automatic test_alias();
    logic [63:0] v, a;
    v = {$urandom(), $urandom()};
    a = rand_addr(9);
    a[63:32] = a[63:32] | 32'h8000_0001;
    run_cycle(NONE, 64'h0, 64'h0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      if (c == 1)      run_cycle(STORE, a, v, 1'b0);
      else if (c == 3) run_cycle(LOAD, 64'h24, 64'h0, 1'b0);
      else             run_cycle(NONE, 64'h0, 64'h0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL alias_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
      if (c == 7) begin
        checks++;
        if (obs_v[0][67:0] !== {4'd2, v}) begin
          errors++;
          $display("FAIL alias_load: got %h, expected %h", obs_v[0][67:0], {4'd2, v});
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    logic rst;
    for (int i = 0; i < 400; i++) begin
      cmd = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      run_cycle(cmd, rand_addr($urandom_range(0, 15)), {$urandom(), $urandom()}, rst);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL random_model dut%0d cycle %0d: got %h, expected %h", k, cyc, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    tagc[0] = 4'd1;
    tagc[1] = 4'd1;
    reset   = 1'b1;
    bus0.proc2mem_command = NONE;
    bus0.proc2mem_address = 64'h0;
    bus0.proc2mem_data    = 64'h0;
    bus1.proc2mem_command = NONE;
    bus1.proc2mem_address = 64'h0;
    bus1.proc2mem_data    = 64'h0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_store_load();
    test_prime();
    test_back_to_back();
    test_tag_wrap();
    test_reset_midflight();
    test_alias();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_tagged_responder.md
MEM_TAGGED_RESPONDER -- requirements
Module: mem_tagged_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to tagged completion; legal range 2..15.
REQ-002 Parameter DEPTH, default 4: maximum in-flight requests; legal range 1..15.
REQ-003 Parameter MEM_WORDS, default 1024: number of 64-bit storage words; power of two.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 proc2mem_command  input  2  2'b00 = BUS_NONE, 2'b01 = BUS_LOAD, 2'b10 = BUS_STORE, 2'b11 = treated as BUS_NONE.
REQ-007 proc2mem_address  input  64  byte address; word index = address[63:2] modulo MEM_WORDS.
REQ-008 proc2mem_data  input  64  store data, sampled only on an accepted BUS_STORE.
REQ-009 mem2proc_response  output  4  combinational; 0 = request not accepted, 1..15 = tag assigned to the request this cycle.
REQ-010 mem2proc_data  output  64  registered; load data during a load completion, 0 otherwise.
REQ-011 mem2proc_tag  output  4  registered; tag of the request completing this cycle, 0 = no completion.

Function
REQ-012 A request is accepted in a cycle iff command is LOAD or STORE, not reset, and the in-flight count after this cycle's completion is below DEPTH.
REQ-013 mem2proc_response equals the tag counter value when accepted, 0 otherwise (including for BUS_NONE and 2'b11).
REQ-014 Tag counter starts at 1 and advances only on acceptance: 1,2,...,15,1; value 0 is never issued.
REQ-015 Accepted STORE writes proc2mem_data to the indexed word at the accepting clock edge.
REQ-016 Accepted LOAD captures the indexed word at the accepting edge, so a LOAD accepted in the cycle after a STORE to the same word returns the new data.
REQ-017 A request accepted in cycle N completes in cycle N+LATENCY: mem2proc_tag = its tag for exactly one cycle.
REQ-018 Completions are strictly in acceptance order; at most one completion per cycle; tag is 0 in all other cycles.
REQ-019 During a LOAD completion mem2proc_data = captured word; during a STORE completion and idle cycles mem2proc_data = 0.
REQ-020 In-flight tracking: FIFO of DEPTH entries {tag, is_load, data, age}; entry popped in its completion cycle.
REQ-021 Full boundary: when count == DEPTH and a completion occurs this cycle, the freed slot is reusable and a new request is accepted in the same cycle.
REQ-022 Full boundary: when count == DEPTH and no completion occurs this cycle, response is 0 and no state changes except aging.
REQ-023 Empty boundary: no completion is emitted when the FIFO is empty; tag and data outputs hold 0.
REQ-024 Address bits above log2(MEM_WORDS)+1 are ignored (wrap-around aliasing).

Reset
REQ-025 On reset: FIFO emptied, in-flight requests discarded with no completion emitted, tag counter = 1, mem2proc_tag = 0, mem2proc_data = 0.
REQ-026 mem2proc_response is 0 in any cycle where reset is high.
REQ-027 Memory contents are not modified by reset.

Configuration
REQ-028 Macro MEM_RESP_STALL_INJECT_EN: when defined, a free-running 2-bit counter (reset to 0) forces response 0 in every cycle where the counter equals 3, regardless of FIFO space; completions are unaffected.
REQ-029 Without MEM_RESP_STALL_INJECT_EN, acceptance depends only on REQ-012.

Verification
REQ-030 STORE addr 0x10 data 0xDEADBEEF_00000001 in cycle 1, LOAD addr 0x10 in cycle 2 -> responses 1 and 2; tag 1 with data 0 in cycle 5; tag 2 with data 0xDEADBEEF_00000001 in cycle 6.
REQ-031 Back-to-back LOADs every cycle with DEPTH=4, LATENCY=4 -> all accepted; one completion per cycle from cycle 5; tags in order.
REQ-032 DEPTH=2, LATENCY=4, LOAD every cycle -> cycles 1,2 accepted; cycles 3,4 response 0; cycle 5 accepted (completion frees slot in that cycle).
REQ-033 17 accepted requests -> tags 1..15 then 1,2; no tag 0 issued.
REQ-034 Three LOADs issued, reset asserted 2 cycles later for 1 cycle -> no completion emitted afterwards; next accepted request gets tag 1; previously stored data still readable.
REQ-035 With MEM_RESP_STALL_INJECT_EN, LOAD every cycle from reset release -> response 0 in cycles 4,8,12; other cycles accepted.
